sprite_compositor: RTL

Parametrised multi-channel sprite compositor for the VGA game path. It takes the VGA scan counters and per-channel sprite positions, fetches one bitmap row per channel from external row ROMs, and resolves the final pixel using fixed priority. It also detects per-channel sprite overlap. Positions are shadow-latched at frame start so that no sprite tears mid-frame. Collision flags are accumulated per frame and published as a stable snapshot, which replaces the ad-hoc per-pixel layer/collide logic in the game top level.

---
 rtl/sprite_compositor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - three-stage multi-channel sprite compositor with per-frame collision snapshot
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = 48,
    parameter int SPR_H       = 48,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int RA_W        = 6,
    localparam int ID_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [X_W-1:0]                haddress,
    input  logic [Y_W-1:0]                vaddress,
    input  logic                          active,
    input  logic                          frame_start,
    input  logic [NUM_SPRITES*X_W-1:0]    spr_x,
    input  logic [NUM_SPRITES*Y_W-1:0]    spr_y,
    input  logic [NUM_SPRITES-1:0]        spr_en,
    input  logic [NUM_SPRITES-1:0]        spr_flip,
    output logic [NUM_SPRITES*RA_W-1:0]   spr_row_addr,
    input  logic [NUM_SPRITES*SPR_W-1:0]  spr_row_data,
    output logic                          pixel_on,
    output logic [ID_W-1:0]               pixel_id,
    output logic [NUM_SPRITES-1:0]        coll_frame,
    output logic                          coll_valid
);

    localparam int CW    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int H_VIS = 640;
    localparam int V_VIS = 480;

    logic [X_W-1:0]         sh_x [NUM_SPRITES];
    logic [Y_W-1:0]         sh_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] sh_en;
    logic [NUM_SPRITES-1:0] sh_flip;

    logic [X_W:0]           dx [NUM_SPRITES];
    logic [Y_W:0]           dy [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] in_c;
    logic [CW-1:0]          col_c [NUM_SPRITES];
    logic [RA_W-1:0]        row_c [NUM_SPRITES];
    logic                   on_screen;

    logic [NUM_SPRITES-1:0] in1;
    logic [CW-1:0]          col1 [NUM_SPRITES];
    logic                   fs1;

    logic [SPR_W-1:0]       row_word [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] hit_c;
    logic [NUM_SPRITES-1:0] hit2;
    logic                   fs2;

    logic [NUM_SPRITES-1:0] coll_now;
    logic [NUM_SPRITES-1:0] coll_live;
    logic [ID_W-1:0]        id_c;

    // Shadow copies keep a sprite from tearing when the game moves it mid-frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i] <= '0;
                sh_y[i] <= '0;
            end
            sh_en   <= '0;
            sh_flip <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i] <= spr_x[i*X_W +: X_W];
                sh_y[i] <= spr_y[i*Y_W +: Y_W];
            end
            sh_en   <= spr_en;
            sh_flip <= spr_flip;
        end
    end

    always_comb begin
        on_screen = active && ({1'b0, haddress} < (X_W+1)'(H_VIS))
                           && ({1'b0, vaddress} < (Y_W+1)'(V_VIS));
        for (int i = 0; i < NUM_SPRITES; i++) begin
            dx[i]    = {1'b0, haddress} - {1'b0, sh_x[i]};
            dy[i]    = {1'b0, vaddress} - {1'b0, sh_y[i]};
            in_c[i]  = sh_en[i] & on_screen & ~dx[i][X_W] & ~dy[i][Y_W]
                     & (dx[i] < (X_W+1)'(SPR_W)) & (dy[i] < (Y_W+1)'(SPR_H));
            // dx < SPR_W whenever it matters, so the low bits carry the full column
            col_c[i] = sh_flip[i] ? (CW'(SPR_W-1) - dx[i][CW-1:0]) : dx[i][CW-1:0];
            row_c[i] = in_c[i] ? dy[i][RA_W-1:0] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in1          <= '0;
            fs1          <= 1'b0;
            spr_row_addr <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) col1[i] <= '0;
        end else begin
            in1 <= in_c;
            fs1 <= frame_start;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                col1[i]                        <= col_c[i];
                spr_row_addr[i*RA_W +: RA_W]   <= row_c[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            row_word[i] = spr_row_data[i*SPR_W +: SPR_W];
            hit_c[i]    = in1[i] & row_word[i][col1[i]];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit2 <= '0;
            fs2  <= 1'b0;
        end else begin
            hit2 <= hit_c;
            fs2  <= fs1;
        end
    end

    // Clearing the lowest set bit leaves something only when two or more channels hit
    always_comb begin
        coll_now = (|(hit2 & (hit2 - NUM_SPRITES'(1)))) ? hit2 : '0;
        id_c     = '0;
        for (int i = NUM_SPRITES-1; i >= 0; i--) begin
            if (hit2[i]) id_c = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_on   <= 1'b0;
            pixel_id   <= '0;
            coll_valid <= 1'b0;
            coll_frame <= '0;
            coll_live  <= '0;
        end else begin
            pixel_on   <= |hit2;
            pixel_id   <= id_c;
            coll_valid <= fs2;
            if (fs2) begin
                coll_frame <= coll_live | coll_now;
                coll_live  <= '0;
            end else begin
                coll_live  <= coll_live | coll_now;
            end
        end
    end

endmodule
